// File: rtl/serial_full_subtractor.sv
// serial_full_subtractor
//   Bit-serial WIDTH-bit subtractor: DIFF = A - B - Bin, one bit per clock, LSB first, using a
//   single full-subtractor cell and a borrow register. start/busy/done handshake.
//
// Ports
//   clk    in   1      clock, all state updates on rising edge
//   rst_n  in   1      synchronous active-low reset
//   start  in   1      request, accepted only when idle
//   a      in   WIDTH  minuend, sampled on the accepting edge
//   b      in   WIDTH  subtrahend, sampled on the accepting edge
//   bin    in   1      borrow-in, sampled on the accepting edge
//   diff   out  WIDTH  difference (registered, valid from done until next accept)
//   bout   out  1      borrow-out of the MSB stage (registered)
//   ovf    out  1      signed two's-complement overflow (registered)
//   busy   out  1      high while running or done
//   done   out  1      one-cycle pulse, result valid
module serial_full_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;

  // Full-subtractor cell on the current LSBs.
  logic x, y, r, d_bit, borrow_nxt;

  always_comb begin
    x          = sa_q[0];
    y          = sb_q[0];
    r          = borrow_q;
    d_bit      = x ^ y ^ r;
    borrow_nxt = (~x & y) | (~(x ^ y) & r);
  end

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    diff_d   = diff_q;
    count_d  = count_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRun;
          sa_d     = a;
          sb_d     = b;
          borrow_d = bin;
          count_d  = '0;
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
        end
      end
      StRun: begin
        diff_d   = {d_bit, diff_q[WIDTH-1:1]};
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        borrow_d = borrow_nxt;
        count_d  = count_q + 1'b1;
        if (count_q == LastCnt) begin
          state_d = StDone;
          count_d = '0;
          bout_d  = borrow_nxt;
          // d_bit is the MSB difference bit on this final step.
          ovf_d   = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sa_q     <= '0;
      sb_q     <= '0;
      diff_q   <= '0;
      count_q  <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      diff_q   <= diff_d;
      count_q  <= count_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
    end
  end

  always_comb begin
    diff = diff_q;
    bout = bout_q;
    ovf  = ovf_q;
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

endmodule
